// File: rtl/beat_tone_pkg.sv
// rtl/beat_tone_pkg.sv - note table, FSM state type and half-period helper for beat_tone_gen
package beat_tone_pkg;

    localparam int N_NOTES = 13;
    localparam logic [3:0] IDLE_IDX = 4'hF;

    // Chromatic scale C4..C5 in Hz
    localparam int NOTE_HZ [N_NOTES] = '{262, 277, 294, 311, 330, 349, 370,
                                          392, 415, 440, 466, 494, 523};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        PLAY = 2'd2
    } state_t;

    function automatic int half_period(input int clk_hz, input int idx);
        return clk_hz / (2 * NOTE_HZ[idx]);
    endfunction

endpackage

// File: rtl/beat_tone_gen_onehot_dec.sv
// rtl/beat_tone_gen_onehot_dec.sv - classifies a one-hot note code into valid/bad and its bit index
module onehot_dec
    import beat_tone_pkg::*;
(
    input  logic [N_NOTES-1:0] i_code,
    output logic               o_valid,
    output logic               o_bad,
    output logic [3:0]         o_idx
);

    logic [3:0] w_ones;

    always_comb begin
        w_ones = 4'd0;
        o_idx  = 4'd0;
        for (int i = 0; i < N_NOTES; i++) begin
            if (i_code[i]) begin
                w_ones = w_ones + 4'd1;
                o_idx  = 4'(i);
            end
        end
        o_valid = (w_ones == 4'd1);
        o_bad   = (w_ones > 4'd1);
    end

endmodule

// File: rtl/beat_tone_gen.sv
// rtl/beat_tone_gen.sv - one-hot note code to piezo square wave with inter-note gap
// Optional BEAT_TONE_OCTAVE_EN adds octave_up, halving the half-period per note.
module beat_tone_gen
    import beat_tone_pkg::*;
#(
    parameter int CLK_HZ  = 1000000,
    parameter int CNT_W   = 20,
    parameter int GAP_CYC = 1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_NOTES-1:0] beat,
    input  logic               light,
    input  logic               mute,
`ifdef BEAT_TONE_OCTAVE_EN
    input  logic               octave_up,
`endif
    output logic               piezo,
    output logic [3:0]         note_idx,
    output logic               playing,
    output logic               led,
    output logic               err
);

    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);

    logic [N_NOTES-1:0] r_beat_q;
    state_t             r_state;
    logic [3:0]         r_idx;
    logic [CNT_W-1:0]   r_gap_cnt;
    logic [CNT_W-1:0]   r_half_cnt;
    logic [CNT_W-1:0]   r_half;
    logic               r_piezo;
    logic               r_led;
    logic               r_err;
    logic               r_bad_prev;

    logic               w_valid;
    logic               w_bad;
    logic [3:0]         w_dec_idx;
    logic [CNT_W-1:0]   w_half_tbl [N_NOTES];
    logic [CNT_W-1:0]   w_eff_half;

    state_t             w_state_nxt;
    logic [3:0]         w_idx_nxt;
    logic [CNT_W-1:0]   w_gap_nxt;
    logic [CNT_W-1:0]   w_half_cnt_nxt;
    logic [CNT_W-1:0]   w_half_nxt;
    logic               w_piezo_nxt;

    onehot_dec u_dec (
        .i_code  (r_beat_q),
        .o_valid (w_valid),
        .o_bad   (w_bad),
        .o_idx   (w_dec_idx)
    );

    for (genvar g = 0; g < N_NOTES; g++) begin : g_half
        assign w_half_tbl[g] = CNT_W'(half_period(CLK_HZ, g));
    end

    // Octave choice is captured into r_half on GAP->PLAY and held for the whole note
`ifdef BEAT_TONE_OCTAVE_EN
    assign w_eff_half = octave_up ? (w_half_tbl[r_idx] >> 1) : w_half_tbl[r_idx];
`else
    assign w_eff_half = w_half_tbl[r_idx];
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_gap_nxt      = r_gap_cnt;
        w_half_cnt_nxt = r_half_cnt;
        w_half_nxt     = r_half;
        w_piezo_nxt    = r_piezo;
        unique case (r_state)
            IDLE: begin
                w_piezo_nxt = 1'b0;
                if (w_valid) begin
                    w_state_nxt = GAP;
                    w_idx_nxt   = w_dec_idx;
                    w_gap_nxt   = GAP_LOAD;
                end
            end
            GAP, PLAY: begin
                if (!w_valid) begin
                    w_state_nxt = IDLE;
                    w_piezo_nxt = 1'b0;
                end else if (w_dec_idx != r_idx) begin
                    // New note cuts the current one immediately, no period completion
                    w_state_nxt = GAP;
                    w_idx_nxt   = w_dec_idx;
                    w_gap_nxt   = GAP_LOAD;
                    w_piezo_nxt = 1'b0;
                end else if (r_state == GAP) begin
                    w_piezo_nxt = 1'b0;
                    if (r_gap_cnt == '0) begin
                        w_state_nxt    = PLAY;
                        w_half_nxt     = w_eff_half;
                        w_half_cnt_nxt = w_eff_half - 1'b1;
                    end else begin
                        w_gap_nxt = r_gap_cnt - 1'b1;
                    end
                end else begin
                    if (r_half_cnt == '0) begin
                        w_piezo_nxt    = ~r_piezo;
                        w_half_cnt_nxt = r_half - 1'b1;
                    end else begin
                        w_half_cnt_nxt = r_half_cnt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_piezo_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_beat_q   <= '0;
            r_state    <= IDLE;
            r_idx      <= IDLE_IDX;
            r_gap_cnt  <= '0;
            r_half_cnt <= '0;
            r_half     <= '0;
            r_piezo    <= 1'b0;
            r_led      <= 1'b0;
            r_err      <= 1'b0;
            r_bad_prev <= 1'b0;
        end else begin
            r_beat_q   <= beat;
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_half_cnt <= w_half_cnt_nxt;
            r_half     <= w_half_nxt;
            r_piezo    <= w_piezo_nxt;
            r_led      <= light;
            // Edge-detect so a held bad code flags only once
            r_err      <= w_bad & ~r_bad_prev;
            r_bad_prev <= w_bad;
        end
    end

    // Mute gates after the register so the tone grid keeps running underneath
    assign piezo    = r_piezo & ~mute;
    assign playing  = (r_state == PLAY);
    assign note_idx = (r_state == IDLE) ? IDLE_IDX : r_idx;
    assign led      = r_led;
    assign err      = r_err;

endmodule

// File: tb/tb_beat_tone_gen.sv
// tb/tb_beat_tone_gen.sv - directed self-checking bench for beat_tone_gen
`timescale 1ns/1ps
module tb_beat_tone_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic [12:0] beat;
    logic        light;
    logic        mute;
`ifdef BEAT_TONE_OCTAVE_EN
    logic        octave_up;
`endif
    logic        piezo;
    logic [3:0]  note_idx;
    logic        playing;
    logic        led;
    logic        err;

    int n_checks = 0;
    int n_fails  = 0;

    beat_tone_gen #(
        .CLK_HZ  (1000000),
        .CNT_W   (20),
        .GAP_CYC (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .beat     (beat),
        .light    (light),
        .mute     (mute),
`ifdef BEAT_TONE_OCTAVE_EN
        .octave_up(octave_up),
`endif
        .piezo    (piezo),
        .note_idx (note_idx),
        .playing  (playing),
        .led      (led),
        .err      (err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Cycles until piezo changes level; -1 if it never does within the bound
    task automatic wait_toggle(output int n);
        logic start;
        start = piezo;
        n = -1;
        for (int i = 1; i <= 5000; i++) begin
            tick(1);
            if (piezo !== start) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        beat  = '0;
        mute  = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    int n;
    int viol;

    initial begin
        reset = 1'b1;
        beat  = '0;
        light = 1'b0;
        mute  = 1'b0;
`ifdef BEAT_TONE_OCTAVE_EN
        octave_up = 1'b0;
`endif
        tick(2);
        check_eq("rst_piezo", int'(piezo), 0);
        check_eq("rst_idx", int'(note_idx), 15);
        check_eq("rst_playing", int'(playing), 0);
        check_eq("rst_led", int'(led), 0);
        check_eq("rst_err", int'(err), 0);
        reset = 1'b0;

        // 1: A4, gap latency and half period
        beat = 13'b0001000000000;
        tick(1);
        check_eq("a4_beatq_play", int'(playing), 0);
        tick(4);
        check_eq("a4_gap_play", int'(playing), 0);
        check_eq("a4_gap_idx", int'(note_idx), 9);
        tick(1);
        check_eq("a4_play", int'(playing), 1);
        check_eq("a4_piezo0", int'(piezo), 0);
        wait_toggle(n);
        check_eq("a4_first_rise", n, 1136);
        check_eq("a4_high", int'(piezo), 1);
        wait_toggle(n);
        check_eq("a4_fall", n, 1136);
        check_eq("a4_idx", int'(note_idx), 9);
        beat = '0;
        tick(2);
        check_eq("rest_playing", int'(playing), 0);
        check_eq("rest_idx", int'(note_idx), 15);
        check_eq("rest_piezo", int'(piezo), 0);

        // 2: C4 then switch to C5 mid-period
        do_reset();
        beat = 13'b0000000000001;
        tick(6);
        check_eq("c4_play", int'(playing), 1);
        check_eq("c4_idx", int'(note_idx), 0);
        wait_toggle(n);
        check_eq("c4_rise", n, 1908);
        tick(500);
        beat = 13'b1000000000000;
        tick(1);
        check_eq("sw_beatq_piezo", int'(piezo), 1);
        tick(1);
        check_eq("sw_piezo0", int'(piezo), 0);
        check_eq("sw_playing", int'(playing), 0);
        check_eq("sw_idx", int'(note_idx), 12);
        tick(3);
        check_eq("sw_gap", int'(playing), 0);
        tick(1);
        check_eq("sw_play", int'(playing), 1);
        wait_toggle(n);
        check_eq("c5_rise", n, 956);

        // 3: two bits set
        do_reset();
        beat = 13'b1000001000000;
        tick(1);
        check_eq("bad_err_early", int'(err), 0);
        tick(1);
        check_eq("bad_err", int'(err), 1);
        check_eq("bad_idx", int'(note_idx), 15);
        check_eq("bad_playing", int'(playing), 0);
        check_eq("bad_piezo", int'(piezo), 0);
        tick(1);
        check_eq("bad_err_once", int'(err), 0);
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (err !== 1'b0) viol++;
        end
        check_eq("bad_err_held", viol, 0);
        beat = '0;
        tick(2);
        beat = 13'b0000000000011;
        tick(2);
        check_eq("bad_err_refire", int'(err), 1);

        // 4: mute across a toggle, grid preserved; 5 uses the same note
        do_reset();
        light = 1'b1;
        beat  = 13'b0001000000000;
        tick(6);
        check_eq("led_on", int'(led), 1);
        wait_toggle(n);
        check_eq("mute_pre_rise", n, 1136);
        tick(900);
        mute = 1'b1;
        viol = 0;
        for (int i = 0; i < 500; i++) begin
            #1;
            if (piezo !== 1'b0) viol++;
            tick(1);
        end
        check_eq("mute_silent", viol, 0);
        mute = 1'b0;
        #1;
        check_eq("unmute_low", int'(piezo), 0);
        wait_toggle(n);
        check_eq("unmute_grid", n, 872);

        // 5: reset mid-PLAY
        check_eq("pre_rst_playing", int'(playing), 1);
        reset = 1'b1;
        tick(1);
        check_eq("mid_rst_piezo", int'(piezo), 0);
        check_eq("mid_rst_playing", int'(playing), 0);
        check_eq("mid_rst_idx", int'(note_idx), 15);
        check_eq("mid_rst_led", int'(led), 0);
        reset = 1'b0;
        tick(1);
        check_eq("led_after_rst", int'(led), 1);
        light = 1'b0;
        tick(1);
        check_eq("led_off", int'(led), 0);

`ifdef BEAT_TONE_OCTAVE_EN
        // 6: octave up, latched per note
        do_reset();
        octave_up = 1'b1;
        beat = 13'b0001000000000;
        tick(6);
        check_eq("oct_play", int'(playing), 1);
        wait_toggle(n);
        check_eq("oct_rise", n, 568);
        octave_up = 1'b0;
        wait_toggle(n);
        check_eq("oct_hold", n, 568);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/beat_tone_gen.md
Name: beat_tone_gen

Overview:
Consumer side of the alarm pattern interface. It takes the 13-bit one-hot `beat` note code and the `light` flag produced by the alarm sequencer, and drives a square wave onto the piezo buzzer at the coded note frequency.
- A short silent gap separates consecutive notes.
- Codes that are not one-hot are rejected and flagged.
- Sits between the alarm sequencer and the buzzer pin.

Parameters:
- CLK_HZ, 1000000: clock frequency in Hz; used for half-period computation at elaboration.
- CNT_W, 20: width of the half-period and gap counters. Must hold the largest HALF and GAP_CYC.
- GAP_CYC, 1000: silent cycles inserted before each new note. Must be >= 1.

Ports:
- clock, input, 1: single system clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- beat, input, 13: one-hot note code. Bit i = note i; 0 = rest.
- light, input, 1: accent flag from the sequencer; passed through registered.
- mute, input, 1: level; forces silence without changing the FSM.
- piezo, output, 1: square-wave buzzer drive.
- note_idx, output, 4: index of the note currently in GAP/PLAY; 4'hF when IDLE.
- playing, output, 1: high in PLAY.
- led, output, 1: registered copy of `light`.
- err, output, 1: one-cycle pulse on a rejected code.

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE; beat_q = 0.
  - piezo = 0, note_idx = 4'hF, playing = 0, led = 0, err = 0.
  - All counters 0.
- Input stage: beat registered into beat_q every cycle; the FSM acts on beat_q. Input-to-decision latency is 1 cycle.
- Note table (package constant NOTE_HZ[0..12], chromatic C4..C5): 262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494, 523.
- Half-period: HALF[i] = CLK_HZ / (2*NOTE_HZ[i]), integer truncation, computed at elaboration.
- Code classification of beat_q:
  - ZERO = all bits 0.
  - VALID = exactly one bit set.
  - BAD = two or more bits set.
- IDLE:
  - piezo = 0.
  - VALID → GAP; latch idx; gap counter loaded GAP_CYC-1.
  - BAD → err pulse, stay IDLE.
- GAP:
  - piezo = 0; gap counter decrements.
  - At 0 → PLAY; half counter loaded HALF[idx]-1.
- PLAY:
  - Half counter decrements; at 0, piezo toggles and the counter reloads HALF[idx]-1.
  - Period is exactly 2*HALF cycles; first rising edge comes HALF cycles after entering PLAY.
- Transitions out of GAP or PLAY:
  - beat_q ZERO → IDLE; piezo forced 0 the same edge.
  - beat_q VALID with a different idx → GAP with the new idx; piezo forced 0 the same edge. No partial-period completion.
  - beat_q BAD → IDLE + err pulse.
  - Same idx held → no disturbance.
- mute=1:
  - piezo output gated to 0 combinationally after the register.
  - FSM and counters keep running, so unmuting resumes mid-period with no glitch reset.
- led follows light with 1-cycle latency, independent of FSM state.
- Reset asserted mid-note: all state cleared on that edge; piezo is 0 on the next cycle.
- Simultaneous events: err and a state change on the same edge are allowed; err is a single-cycle pulse even if BAD is held, re-firing only after a non-BAD cycle.

Optional Feature:
- Macro: BEAT_TONE_OCTAVE_EN.
- When defined:
  - Extra input `octave_up` (1 bit), sampled at each GAP→PLAY entry.
  - If 1, the effective half-period is HALF[idx] >> 1 (one octave higher) for that whole note.
  - Changing `octave_up` during PLAY has no effect until the next note.
- When undefined: port absent; HALF[idx] always used.

Decomposition:
- Package beat_tone_pkg:
  - NOTE_HZ array, N_NOTES = 13, IDLE_IDX = 4'hF.
  - State enum {IDLE, GAP, PLAY}.
  - Function half_period(clk_hz, idx).
- Sub-module onehot_dec:
  - Combinational; 13-bit input → {valid, bad, idx[3:0]}.
  - Reused by any other consumer of `beat`.

Test Plan:
All cases use CLK_HZ = 1000000 and GAP_CYC = 4.
1. Reset, then beat = 13'b0001000000000 (bit 9, A4):
   - playing rises 1+4 cycles after beat_q updates.
   - piezo toggles every 1136 cycles (period 2272).
   - note_idx = 9.
2. Bit 0 (C4) played, then switched to bit 12 (C5) mid-period:
   - piezo goes 0 on the decision edge; 4-cycle gap.
   - New half-period 956; note_idx 0 → 12.
3. beat = 13'b1000001000000 (two bits set):
   - err pulses exactly once; state IDLE; piezo 0; note_idx = 4'hF.
4. During PLAY of bit 9:
   - mute=1 for 500 cycles: piezo 0 throughout.
   - Unmute: piezo toggle points still fall on the original 1136-cycle grid.
5. reset asserted mid-PLAY:
   - Next cycle: piezo = 0, playing = 0, note_idx = 4'hF, led = 0.
   - Then light=1: led = 1 one cycle later.
6. BEAT_TONE_OCTAVE_EN defined, octave_up = 1, bit 9:
   - Toggle every 568 cycles.
   - Dropping octave_up mid-note leaves 568 unchanged.
